call_registry: RTL and testbench

Clocked, parametrised successor to the combinational button latch: it registers cabin calls and hall up/down calls for `FLOORS` floors and synchronises asynchronous button inputs. It optionally debounces them, then latches each call on the rising edge of a press. It derives direction summaries relative to the car's current floor. It sits between the panel inputs and the elevator controller FSM, which consumes the summaries and pulses the clear inputs when a floor is served.

---
 rtl/call_registry.sv | 143 ++++++++++++++
 tb/tb_call_registry.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_registry.sv
// call_registry: synchronises, optionally debounces (CALL_DEBOUNCE_EN) and latches cabin
// and hall calls per floor, and derives direction summaries relative to current_floor.

module call_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic allow,
  input  logic clr,
  output logic active
);
`ifdef CALL_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic s1, s2, deb, deb_nxt;

  // A one-cycle debounce window behaves exactly like a plain register, so no counter then.
  if (DEB_EN && DEBOUNCE_CYCLES > 1) begin : g_deb
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [CW-1:0] cnt, cnt_nxt;

    always_comb begin
      deb_nxt = deb;
      cnt_nxt = '0;
      if (s2 != deb) begin
        if (int'(cnt) == DEBOUNCE_CYCLES - 1) deb_nxt = s2;
        else                                  cnt_nxt = cnt + CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt_nxt;
    end
  end else begin : g_nodeb
    assign deb_nxt = s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      deb    <= 1'b0;
      active <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      deb <= deb_nxt;
      if (clr)                           active <= 1'b0;
      else if (deb_nxt && !deb && allow) active <= 1'b1;
    end
  end
endmodule

module call_registry #(
  parameter int FLOORS          = 8,
  parameter int FLOOR_BITS      = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             buttons_blocked,
  input  logic                   door_open,
  input  logic [FLOOR_BITS-1:0]  current_floor,
  input  logic [FLOORS-1:0]      btn_in,
  input  logic [FLOORS-1:0]      btn_up_out,
  input  logic [FLOORS-1:0]      btn_down_out,
  input  logic [FLOORS-1:0]      inactivate_in_levels,
  input  logic [FLOORS-1:0]      inactivate_out_up_levels,
  input  logic [FLOORS-1:0]      inactivate_out_down_levels,
  output logic [FLOORS-1:0]      active_in_levels,
  output logic [FLOORS-1:0]      active_out_up_levels,
  output logic [FLOORS-1:0]      active_out_down_levels,
  output logic                   calls_above,
  output logic                   calls_below,
  output logic                   call_here,
  output logic [COUNT_WIDTH-1:0] pending_count
);
  // Class index: 0 cabin, 1 hall up, 2 hall down.
  logic [2:0][FLOORS-1:0] raw, clr, act, allow;
  logic [FLOORS-1:0]      any;

  assign raw = {btn_down_out, btn_up_out, btn_in};
  assign clr = {inactivate_out_down_levels, inactivate_out_up_levels, inactivate_in_levels};

  always_comb begin
    allow = '1;
    if (buttons_blocked[0]) allow[0] = '0;
    if (buttons_blocked[1]) begin
      allow[1] = '0;
      allow[2] = '0;
    end
    for (int f = 0; f < FLOORS; f++)
      if (door_open && int'(current_floor) == f)
        for (int c = 0; c < 3; c++) allow[c][f] = 1'b0;
    // No up call from the top floor, no down call from the bottom floor.
    allow[1][FLOORS-1] = 1'b0;
    allow[2][0]        = 1'b0;
  end

  for (genvar c = 0; c < 3; c++) begin : g_cls
    for (genvar f = 0; f < FLOORS; f++) begin : g_flr
      call_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw[c][f]),
        .allow  (allow[c][f]),
        .clr    (clr[c][f]),
        .active (act[c][f])
      );
    end
  end

  assign active_in_levels       = act[0];
  assign active_out_up_levels   = act[1];
  assign active_out_down_levels = act[2];

  always_comb begin
    any         = act[0] | act[1] | act[2];
    calls_above = 1'b0;
    calls_below = 1'b0;
    call_here   = 1'b0;
    for (int f = 0; f < FLOORS; f++) begin
      if (int'(current_floor) >= FLOORS)      calls_below = calls_below | any[f];
      else if (f > int'(current_floor))       calls_above = calls_above | any[f];
      else if (f < int'(current_floor))       calls_below = calls_below | any[f];
      else                                    call_here   = call_here | any[f];
    end
  end

  always_comb begin
    pending_count = '0;
    for (int c = 0; c < 3; c++)
      for (int f = 0; f < FLOORS; f++)
        pending_count = pending_count + COUNT_WIDTH'(act[c][f]);
  end
endmodule

// File: tb/tb_call_registry.sv
// Bench for call_registry: directed scenarios plus randomized traffic against a
// vector-level reference model of the call latching rules.
module tb_call_registry;
  localparam int FLOORS = 8, FLOOR_BITS = 4, DC = 4, CW = 5, NB = 3 * FLOORS;
`ifdef CALL_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB_ON = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, door_open = 1'b0;
  logic [1:0] buttons_blocked = '0;
  logic [FLOOR_BITS-1:0] current_floor = '0;
  logic [FLOORS-1:0] btn_in = '0, btn_up_out = '0, btn_down_out = '0;
  logic [FLOORS-1:0] inact_in = '0, inact_up = '0, inact_down = '0;
  logic [FLOORS-1:0] act_in, act_up, act_down;
  logic calls_above, calls_below, call_here;
  logic [CW-1:0] pending_count;

  int n_tests = 0, n_fail = 0;

  call_registry #(.FLOORS(FLOORS), .FLOOR_BITS(FLOOR_BITS), .DEBOUNCE_CYCLES(DC),
                  .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .buttons_blocked(buttons_blocked), .door_open(door_open),
    .current_floor(current_floor), .btn_in(btn_in), .btn_up_out(btn_up_out),
    .btn_down_out(btn_down_out), .inactivate_in_levels(inact_in),
    .inactivate_out_up_levels(inact_up), .inactivate_out_down_levels(inact_down),
    .active_in_levels(act_in), .active_out_up_levels(act_up),
    .active_out_down_levels(act_down), .calls_above(calls_above),
    .calls_below(calls_below), .call_here(call_here), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  // Reference model: flat vectors {down, up, in}; level seen two edges late, then filtered.
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_act = '0;
  int m_run [NB];

  task automatic model_edge();
    logic [NB-1:0] raw, clr, nd, ok;
    raw = {btn_down_out, btn_up_out, btn_in};
    clr = {inact_down, inact_up, inact_in};
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_act = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      return;
    end
    nd = m_deb;
    for (int i = 0; i < NB; i++) begin
      if (!DEB_ON) nd[i] = m_s2[i];
      else if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin nd[i] = m_s2[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    ok = '1;
    if (buttons_blocked[0]) ok[FLOORS-1:0] = '0;
    if (buttons_blocked[1]) ok[NB-1:FLOORS] = '0;
    if (door_open && current_floor < FLOORS) begin
      ok[current_floor] = 1'b0;
      ok[FLOORS + int'(current_floor)] = 1'b0;
      ok[2*FLOORS + int'(current_floor)] = 1'b0;
    end
    ok[2*FLOORS-1] = 1'b0;
    ok[2*FLOORS]   = 1'b0;
    m_act = (m_act | (nd & ~m_deb & ok)) & ~clr;
    m_s2 = m_s1; m_s1 = raw; m_deb = nd;
  endtask

  task automatic model_summary(output logic ab, output logic bl, output logic hr, output int cnt);
    logic [FLOORS-1:0] any, lowmask;
    any = m_act[FLOORS-1:0] | m_act[2*FLOORS-1:FLOORS] | m_act[NB-1:2*FLOORS];
    if (current_floor >= FLOORS) begin
      ab = 1'b0; hr = 1'b0; bl = (any != 0);
    end else begin
      lowmask = (FLOORS'(1) << current_floor) - FLOORS'(1);
      ab = ((any >> (int'(current_floor) + 1)) != 0);
      hr = any[current_floor];
      bl = ((any & lowmask) != 0);
    end
    cnt = $countones(m_act);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    buttons_blocked = '0; door_open = 1'b0; current_floor = '0;
    inact_in = '1; inact_up = '1; inact_down = '1;
    tick();
    inact_in = '0; inact_up = '0; inact_down = '0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_tests++;
    if ({act_in, act_up, act_down, calls_above, calls_below, call_here, pending_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got in=%h up=%h dn=%h sum=%b%b%b cnt=%0d, want all 0",
               act_in, act_up, act_down, calls_above, calls_below, call_here, pending_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latch_basic();
    btn_in = 8'h1F;
    repeat (LAT - 1) tick();
    n_tests++;
    if (act_in !== 8'h00) begin n_fail++; $display("FAIL latch_early: got %h want 00", act_in); end
    tick();
    n_tests++;
    if (act_in !== 8'h1F) begin n_fail++; $display("FAIL latch_edge: got %h want 1f", act_in); end
    n_tests++;
    if (pending_count !== 5'd5) begin n_fail++; $display("FAIL latch_count: got %0d want 5", pending_count); end
    clear_all();
  endtask

  task automatic test_block();
    buttons_blocked = 2'b10;
    btn_in[2] = 1'b1; btn_up_out[4] = 1'b1;
    repeat (LAT) tick();
    n_tests++;
    if (act_in !== 8'h04 || act_up !== 8'h00) begin
      n_fail++; $display("FAIL block_hall: got in=%h up=%h want in=04 up=00", act_in, act_up);
    end
    buttons_blocked = 2'b00;
    repeat (LAT + 2) tick();
    n_tests++;
    if (act_up !== 8'h00) begin n_fail++; $display("FAIL block_not_deferred: got up=%h want 00", act_up); end
    clear_all();
  endtask

  task automatic test_clear_wins();
    btn_up_out[4] = 1'b1;
    repeat (LAT) tick();
    n_tests++;
    if (act_up !== 8'h10) begin n_fail++; $display("FAIL clr_prelatch: got %h want 10", act_up); end
    btn_up_out[4] = 1'b0;
    repeat (LAT + 1) tick();
    btn_up_out[4] = 1'b1;
    repeat (LAT - 1) tick();
    inact_up[4] = 1'b1;
    tick();
    inact_up[4] = 1'b0;
    n_tests++;
    if (act_up !== 8'h00) begin n_fail++; $display("FAIL clear_wins: got %h want 00", act_up); end
    clear_all();
  endtask

  task automatic test_summaries();
    current_floor = 4'd3; door_open = 1'b1;
    btn_in = 8'h48; btn_down_out = 8'h02;
    repeat (LAT) tick();
    n_tests++;
    if (act_in !== 8'h40 || act_down !== 8'h02) begin
      n_fail++; $display("FAIL door_discard: got in=%h dn=%h want in=40 dn=02", act_in, act_down);
    end
    n_tests++;
    if ({calls_above, calls_below, call_here} !== 3'b110) begin
      n_fail++; $display("FAIL summaries: got a/b/h=%b%b%b want 110", calls_above, calls_below, call_here);
    end
    n_tests++;
    if (pending_count !== 5'd2) begin n_fail++; $display("FAIL summ_count: got %0d want 2", pending_count); end
    clear_all();
  endtask

  task automatic test_const_zero();
    btn_up_out = 8'h80; btn_down_out = 8'h01;
    repeat (LAT + 1) tick();
    n_tests++;
    if (act_up !== 8'h00 || act_down !== 8'h00) begin
      n_fail++; $display("FAIL const_zero: got up=%h dn=%h want 00 00", act_up, act_down);
    end
    btn_in[2] = 1'b1;
    repeat (LAT) tick();
    current_floor = 4'd9;
    #1;
    n_tests++;
    if ({calls_above, calls_below, call_here} !== 3'b010 || pending_count !== 5'd1) begin
      n_fail++; $display("FAIL floor_oob: got a/b/h=%b%b%b cnt=%0d want 010 cnt=1",
                         calls_above, calls_below, call_here, pending_count);
    end
    clear_all();
  endtask

  task automatic test_glitch();
    if (DEB_ON) begin
      btn_in[1] = 1'b1;
      repeat (3) tick();
      btn_in[1] = 1'b0;
      repeat (LAT + 3) tick();
      n_tests++;
      if (act_in !== 8'h00) begin n_fail++; $display("FAIL glitch: got %h want 00", act_in); end
      clear_all();
    end
  endtask

  task automatic test_reset_mid();
    btn_in = 8'h11;
    repeat (LAT) tick();
    n_tests++;
    if (act_in !== 8'h11) begin n_fail++; $display("FAIL rst_prelatch: got %h want 11", act_in); end
    reset = 1'b1;
    tick();
    n_tests++;
    if ({act_in, act_up, act_down, calls_above, calls_below, call_here, pending_count} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got in=%h cnt=%0d want all 0", act_in, pending_count);
    end
    reset = 1'b0;
    repeat (LAT - 1) tick();
    n_tests++;
    if (act_in !== 8'h00) begin n_fail++; $display("FAIL relatch_early: got %h want 00", act_in); end
    tick();
    n_tests++;
    if (act_in !== 8'h11 || pending_count !== 5'd2) begin
      n_fail++; $display("FAIL relatch: got %h cnt=%0d want 11 cnt=2", act_in, pending_count);
    end
    clear_all();
  endtask

  task automatic test_random();
    logic ab, bl, hr;
    int cnt;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int f = 0; f < FLOORS; f++) begin
        if ($urandom_range(11) == 0) btn_in[f] = ~btn_in[f];
        if ($urandom_range(11) == 0) btn_up_out[f] = ~btn_up_out[f];
        if ($urandom_range(11) == 0) btn_down_out[f] = ~btn_down_out[f];
        inact_in[f]   = ($urandom_range(24) == 0);
        inact_up[f]   = ($urandom_range(24) == 0);
        inact_down[f] = ($urandom_range(24) == 0);
      end
      if ($urandom_range(15) == 0) buttons_blocked = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) door_open = ~door_open;
      if ($urandom_range(9) == 0) current_floor = FLOOR_BITS'($urandom_range(FLOORS + 1));
      reset = ($urandom_range(149) == 0);
      tick();
      model_summary(ab, bl, hr, cnt);
      n_tests++;
      if ({act_down, act_up, act_in} !== m_act) begin
        n_fail++; $display("FAIL rand_active cyc=%0d: got %h want %h", cyc, {act_down, act_up, act_in}, m_act);
      end
      n_tests++;
      if ({calls_above, calls_below, call_here} !== {ab, bl, hr}) begin
        n_fail++; $display("FAIL rand_summary cyc=%0d: got %b%b%b want %b%b%b", cyc,
                           calls_above, calls_below, call_here, ab, bl, hr);
      end
      n_tests++;
      if (pending_count !== CW'(cnt)) begin
        n_fail++; $display("FAIL rand_count cyc=%0d: got %0d want %0d", cyc, pending_count, cnt);
      end
    end
    reset = 1'b0;
    clear_all();
  endtask

  initial begin
    test_reset();
    test_latch_basic();
    test_block();
    test_clear_wins();
    test_summaries();
    test_const_zero();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
